// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
//  Module : mux4_arb_pkg
//  Shared state encoding and mux-select helper for the 4-way RR arbiter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mux4_arb_pkg;

   localparam int NREQ = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // The shared mux decodes its select inverted: requester i sits at sel = 3-i.
   function automatic logic [1:0] sel_of(input logic [1:0] idx);
      return ~idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
// ============================================================================
//  Module : mux4_rr_arbiter_if
//  Requester-side and output-side handshake bundle of the 4:1 RR arbiter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface mux4_rr_arbiter_if #(
   parameter int DW = 2
);
   logic [DW-1:0] d0;
   logic [DW-1:0] d1;
   logic [DW-1:0] d2;
   logic [DW-1:0] d3;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [1:0]    sel;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    grant_id;
   logic          busy;

   modport master (
      input  d0, d1, d2, d3, req_valid, out_ready,
      output req_ready, sel, out_data, out_valid, grant_id, busy
   );

   modport slave (
      output d0, d1, d2, d3, req_valid, out_ready,
      input  req_ready, sel, out_data, out_valid, grant_id, busy
   );

endinterface

`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ============================================================================
//  Module : rr_pick4
//  Combinational round-robin picker: first request after 'last', wrapping mod 4.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [1:0]      grant,
   output logic            any
);

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [2:0]        shift;
   logic [1:0]        offset;

   // Rotate so that bit 0 is the requester right after 'last'.
   assign shift   = {1'b0, last} + 3'd1;
   assign req_dbl = {req, req} >> shift;
   assign req_rot = req_dbl[NREQ-1:0];

   always_comb begin
      offset = 2'd0;
      any    = 1'b1;
      casez (req_rot)
         4'b???1: offset = 2'd0;
         4'b??10: offset = 2'd1;
         4'b?100: offset = 2'd2;
         4'b1000: offset = 2'd3;
         default: any    = 1'b0;
      endcase
   end

   assign grant = last + 2'd1 + offset;

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  Module : mux4_rr_arbiter
//  Round-robin arbiter/sequencer feeding a registered 2-bit mux output stream.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int DW    = 2,
   parameter int BURST = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   mux4_rr_arbiter_if.master   bus
);

   state_t        state;
   logic [1:0]    grant_id;
   logic [1:0]    last;
   logic [3:0]    beat_cnt;
   logic          out_valid;
   logic [DW-1:0] out_data;

   logic [1:0]    pick;
   logic          pick_any;
   logic [1:0]    sel;
   logic [DW-1:0] mux_out;
   logic          slot_free;
   logic          beat;
   logic          last_beat;
   logic          release_grant;
   logic [3:0]    req_ready;

   rr_pick4 u_pick (
      .req   (bus.req_valid),
      .last  (last),
      .grant (pick),
      .any   (pick_any)
   );

   assign sel = sel_of(grant_id);

   always_comb begin
      mux_out = bus.d0;
      unique case (sel)
         2'b00: mux_out = bus.d3;
         2'b01: mux_out = bus.d2;
         2'b10: mux_out = bus.d1;
         2'b11: mux_out = bus.d0;
      endcase
   end

   assign slot_free     = !out_valid || bus.out_ready;
   assign beat          = (state == ST_GRANT) && bus.req_valid[grant_id] && slot_free;
   assign last_beat     = (beat_cnt == 4'(BURST - 1));
   // An idle requester gives up its grant immediately rather than holding the mux.
   assign release_grant = (state == ST_GRANT) &&
                          (!bus.req_valid[grant_id] || (beat && last_beat));

   always_comb begin
      req_ready = 4'b0000;
      if (state == ST_GRANT) req_ready[grant_id] = slot_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         grant_id  <= 2'd0;
         last      <= 2'd3;
         beat_cnt  <= 4'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (beat) begin
            out_data  <= mux_out;
            out_valid <= 1'b1;
            beat_cnt  <= beat_cnt + 4'd1;
         end else if (bus.out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state    <= ST_GRANT;
                  grant_id <= pick;
               end
            end
            ST_GRANT: begin
               if (release_grant) begin
                  state    <= ST_IDLE;
                  last     <= grant_id;
                  beat_cnt <= 4'd0;
               end
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.sel       = sel;
   assign bus.out_data  = out_data;
   assign bus.out_valid = out_valid;
   assign bus.grant_id  = grant_id;
   assign bus.busy      = (state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  Module : tb_mux4_rr_arbiter
//  Scoreboard bench driving three arbiter instances (BURST 1, 3, 4) in lockstep.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

   localparam int DW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] d0, d1, d2, d3;
   logic [3:0]    req_valid;
   logic          out_ready;
   logic          log_en;
   logic          fair_en;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] dv [4];
   assign dv[0] = d0;
   assign dv[1] = d1;
   assign dv[2] = d2;
   assign dv[3] = d3;

   for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int B = (k == 0) ? 1 : (k == 1) ? 3 : 4;

      mux4_rr_arbiter_if #(.DW(DW)) bus ();
      assign bus.d0        = d0;
      assign bus.d1        = d1;
      assign bus.d2        = d2;
      assign bus.d3        = d3;
      assign bus.req_valid = req_valid;
      assign bus.out_ready = out_ready;

      mux4_rr_arbiter #(.DW(DW), .BURST(B)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      // Reference model of the arbiter, written from the behavioural description.
      logic          m_state;
      logic [1:0]    m_gid, m_last, m_sel, m_pick;
      logic [3:0]    m_cnt, m_rdy;
      logic          m_ov, m_sf, m_beat, m_rel, m_any;
      logic [DW-1:0] sb [$];
      logic [DW-1:0] log [$];
      logic          obs_pop;
      logic [DW-1:0] obs_data;
      int            wcnt [4];
      int            maxw;

      assign m_sel = ~m_gid;

      always_comb begin : p_model
         logic [1:0] cand;
         cand   = 2'd0;
         m_sf   = !m_ov || out_ready;
         m_beat = 1'b0;
         m_rel  = 1'b0;
         m_rdy  = 4'b0000;
         if (m_state) begin
            m_rdy[m_gid] = m_sf;
            m_beat = req_valid[m_gid] && m_sf;
            m_rel  = !req_valid[m_gid] || (m_beat && (m_cnt == 4'(B - 1)));
         end
         m_any  = 1'b0;
         m_pick = m_last;
         for (int j = 1; j <= 4; j++) begin
            cand = m_last + 2'(j);
            if (!m_any && req_valid[cand]) begin
               m_any  = 1'b1;
               m_pick = cand;
            end
         end
      end

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_state <= 1'b0;
            m_gid   <= 2'd0;
            m_last  <= 2'd3;
            m_cnt   <= 4'd0;
            m_ov    <= 1'b0;
            sb.delete();
         end else begin
            if (obs_pop) begin
               if (sb.size() == 0) begin
                  check($sformatf("b%0d_sb_underflow", B), 32'(sb.size()), 32'd1);
               end else begin
                  check($sformatf("b%0d_data", B), 32'(obs_data), 32'(sb[0]));
                  sb.delete(0);
               end
               if (log_en) log.push_back(obs_data);
            end
            if (m_beat) begin
               sb.push_back(dv[m_gid]);
               m_ov  <= 1'b1;
               m_cnt <= m_cnt + 4'd1;
            end else if (out_ready) begin
               m_ov <= 1'b0;
            end
            if (!m_state) begin
               if (m_any) begin
                  m_state <= 1'b1;
                  m_gid   <= m_pick;
               end
            end else if (m_rel) begin
               m_state <= 1'b0;
               m_last  <= m_gid;
               m_cnt   <= 4'd0;
            end
         end
      end

      always @(negedge clk) begin
         obs_pop  <= rst_n && bus.out_valid && out_ready;
         obs_data <= bus.out_data;
         if (rst_n) begin
            check($sformatf("b%0d_sel", B), 32'(bus.sel), 32'(m_sel));
            check($sformatf("b%0d_busy", B), 32'(bus.busy), 32'(m_state));
            check($sformatf("b%0d_req_ready", B), 32'(bus.req_ready), 32'(m_rdy));
            check($sformatf("b%0d_out_valid", B), 32'(bus.out_valid), 32'(m_ov));
            if (m_state) check($sformatf("b%0d_grant_id", B), 32'(bus.grant_id), 32'(m_gid));
            for (int i = 0; i < 4; i++) begin
               if (fair_en && req_valid[i] && !bus.req_ready[i]) wcnt[i] <= wcnt[i] + 1;
               else wcnt[i] <= 0;
               if (fair_en && wcnt[i] > maxw) maxw <= wcnt[i];
            end
         end
      end

      always @(negedge rst_n) begin
         #1;
         check($sformatf("b%0d_rst_out_valid", B), 32'(bus.out_valid), 32'd0);
         check($sformatf("b%0d_rst_busy", B), 32'(bus.busy), 32'd0);
         check($sformatf("b%0d_rst_sel", B), 32'(bus.sel), 32'd3);
         check($sformatf("b%0d_rst_req_ready", B), 32'(bus.req_ready), 32'd0);
         check($sformatf("b%0d_rst_out_data", B), 32'(bus.out_data), 32'd0);
         check($sformatf("b%0d_rst_grant_id", B), 32'(bus.grant_id), 32'd0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int exp_seq [5];
      exp_seq   = '{0, 1, 2, 3, 0};
      rst_n     = 1'b1;
      d0 = 2'd0; d1 = 2'd0; d2 = 2'd0; d3 = 2'd0;
      req_valid = 4'b0000;
      out_ready = 1'b0;
      log_en    = 1'b0;
      fair_en   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         g_inst[0].wcnt[k] = 0;
         g_inst[1].wcnt[k] = 0;
         g_inst[2].wcnt[k] = 0;
      end
      g_inst[0].maxw = 0;
      g_inst[1].maxw = 0;
      g_inst[2].maxw = 0;
      #2 rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;

      // All four requesters, distinct data words.
      d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      log_en    = 1'b1;
      step(14);
      log_en    = 1'b0;
      check("b1_seq_len", 32'(g_inst[0].log.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++)
         if (i < g_inst[0].log.size())
            check($sformatf("b1_seq%0d", i), 32'(g_inst[0].log[i]), 32'(exp_seq[i]));

      // Single requester bursting.
      req_valid = 4'b0100;
      d2 = 2'b10;
      step(12);

      // Downstream stall in the middle of a grant.
      req_valid = 4'b0010;
      d1 = 2'b01;
      step(3);
      out_ready = 1'b0;
      step(5);
      out_ready = 1'b1;
      step(8);

      // Early drop while another requester waits.
      req_valid = 4'b1010;
      d3 = 2'b11;
      step(3);
      req_valid = 4'b1000;
      step(8);

      // Fairness under random competing traffic.
      fair_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         req_valid = {($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'b1};
         d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
         step(1);
      end
      fair_en = 1'b0;
      check("b1_starve", 32'(g_inst[0].maxw <= 12), 32'd1);
      check("b3_starve", 32'(g_inst[1].maxw <= 20), 32'd1);
      check("b4_starve", 32'(g_inst[2].maxw <= 24), 32'd1);

      // Random backpressure, then reset in the middle of activity.
      for (int c = 0; c < 30; c++) begin
         req_valid = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
         step(1);
      end
      req_valid = 4'b1111;
      out_ready = 1'b0;
      step(3);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;

      // Drain everything and confirm nothing was lost.
      out_ready = 1'b1;
      step(6);
      req_valid = 4'b0000;
      step(8);
      check("b1_drain", 32'(g_inst[0].sb.size()), 32'd0);
      check("b3_drain", 32'(g_inst[1].sb.size()), 32'd0);
      check("b4_drain", 32'(g_inst[2].sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
